// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  localparam int unsigned LEN_WIDTH      = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_WIDTH     = 8 * BYTES_PER_WORD;
  localparam int unsigned BCNT_WIDTH     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word shifter; flags the accept that completes a word.
module word_assembler
  import loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic [WORD_WIDTH-1:0] word_c,
  output logic                  word_ready_c
);

  // Only the three earlier bytes need storing; the fourth arrives with word_c.
  logic [WORD_WIDTH-9:0] shift_q, shift_d;
  logic [BCNT_WIDTH-1:0] count_q, count_d;

  assign word_c       = {byte_in, shift_q};
  assign word_ready_c = accept && (count_q == BCNT_WIDTH'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (clear) begin
      shift_d = '0;
      count_d = '0;
    end else if (accept) begin
      shift_d = {byte_in, shift_q[WORD_WIDTH-9:8]};
      count_d = word_ready_c ? '0 : count_q + BCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: length header + little-endian words into instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = CHECK;
`else
  localparam loader_state_t END_STATE = DONE;
`endif

  loader_state_t         state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  words_loaded_q, words_loaded_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic                  core_reset_q, core_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic                  accept_c;
  logic                  clear_c;
  logic [LEN_WIDTH-1:0]  len_hdr_c;
  logic [WORD_WIDTH-1:0] word_c;
  logic                  word_ready_c;

  assign accept_c  = byte_valid && byte_ready_q;
  assign len_hdr_c = {byte_data, len_q[7:0]};

  word_assembler u_word_assembler (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear_c),
    .accept       (accept_c && (state_q == DATA)),
    .byte_in      (byte_data),
    .word_c       (word_c),
    .word_ready_c (word_ready_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    words_loaded_d = words_loaded_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    clear_c        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d          = xor_q;
`endif

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d        = LEN0;
          words_loaded_d = '0;
          clear_c        = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          xor_d          = '0;
`endif
        end
      end
      LEN0: begin
        if (accept_c) begin
          len_d[7:0] = byte_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept_c) begin
          len_d = len_hdr_c;
          if (len_hdr_c == '0) begin
            state_d = END_STATE;
          end else if (len_hdr_c > LEN_WIDTH'(DEPTH_WORDS)) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept_c) begin
`ifdef LOADER_CHECKSUM_EN
          xor_d = xor_q ^ byte_data;
`endif
          if (word_ready_c) begin
            state_d     = WRITE;
            mem_addr_d  = BASE_ADDR + (32'(words_loaded_q) << 2);
            mem_wdata_d = word_c;
          end
        end
      end
      WRITE: begin
        words_loaded_d = words_loaded_q + LEN_WIDTH'(1);
        state_d        = (words_loaded_d == len_q) ? END_STATE : DATA;
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept_c) begin
          state_d = (byte_data == xor_q) ? DONE : ERROR;
        end
`else
        state_d = ERROR;
`endif
      end
      default: state_d = IDLE;
    endcase

    byte_ready_d = (state_d == LEN0) || (state_d == LEN1) ||
                   (state_d == DATA) || (state_d == CHECK);
    mem_we_d     = (state_d == WRITE);
    core_reset_d = (state_d != DONE);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERROR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      len_q          <= '0;
      words_loaded_q <= '0;
      mem_addr_q     <= BASE_ADDR;
      mem_wdata_q    <= '0;
      byte_ready_q   <= 1'b0;
      mem_we_q       <= 1'b0;
      core_reset_q   <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      words_loaded_q <= words_loaded_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      byte_ready_q   <= byte_ready_d;
      mem_we_q       <= mem_we_d;
      core_reset_q   <= core_reset_d;
      done_q         <= done_d;
      error_q        <= error_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q          <= xor_d;
`endif
    end
  end

  assign byte_ready   = byte_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_reset   = core_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the instruction memory. It accepts a byte stream on a valid/ready interface, parses a length header, and assembles little-endian 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses while the core is held in reset. When the load completes it releases the core so that the program counter starts fetching from `BASE_ADDR`.

## Interface

Parameters:
- `BASE_ADDR`, 32'h0: byte address of the first instruction written.
- `DEPTH_WORDS`, 64: instruction memory capacity in words. Headers requesting more than this are rejected.

Ports:
- `clock`  in  1  single clock; all state is updated on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load. Sampled only in IDLE, DONE and ERROR.
- `byte_valid`  in  1  source offers `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts the byte this cycle.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  32  byte address of the write, `BASE_ADDR + 4*index`.
- `mem_wdata`  out  32  assembled instruction word.
- `core_reset`  out  1  holds the program counter and instruction register in reset while high.
- `done`  out  1  load completed successfully; stays high until the next `start` or reset.
- `error`  out  1  load aborted; stays high until the next `start` or reset.
- `words_loaded`  out  16  count of words written so far.

## Operation

- A byte is transferred only when `byte_valid && byte_ready` at a rising edge.
- States:
  - IDLE: `byte_ready`=0. `start` moves to LEN0.
  - LEN0: accept the low length byte, then go to LEN1.
  - LEN1: accept the high length byte, then:
    - if length is 0, go to CHECK (when the checksum is compiled in) or DONE;
    - if length > `DEPTH_WORDS`, go to ERROR;
    - otherwise go to DATA.
  - DATA: accept bytes into the shift register, byte 0 into bits [7:0]. After the 4th byte, go to WRITE.
  - WRITE: `byte_ready`=0 and `mem_we`=1 for exactly one cycle; `words_loaded` increments.
    - If `words_loaded` (after increment) equals the length, go to CHECK/DONE.
    - Otherwise return to DATA.
  - CHECK: present only with the checksum compiled in; see Configuration.
  - DONE: `done`=1, `core_reset`=0. `start` re-enters LEN0 and clears `done` and `words_loaded`.
  - ERROR: `error`=1, `core_reset`=1. `start` re-enters LEN0 and clears `error`.
- `core_reset`=1 in every state except DONE.
- `mem_addr` is computed from the index before the increment, so word 0 is written to `BASE_ADDR`.
- A `start` pulse while in LEN0, LEN1, DATA, WRITE or CHECK is ignored.
- `byte_valid` low stalls the FSM indefinitely. There is no timeout.

## Timing

- Reset values:
  - state IDLE;
  - `byte_ready`=0, `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0;
  - `core_reset`=1, `done`=0, `error`=0, `words_loaded`=0.
- `byte_ready` is registered from state: high in LEN0, LEN1, DATA and CHECK.
- `mem_we` rises the cycle after the 4th data byte is accepted. `mem_addr` and `mem_wdata` are stable during that cycle.
- Throughput: 5 cycles per word with a continuously valid source (4 accept cycles plus 1 write cycle).
- `core_reset` falls on the same edge that enters DONE.
- An asynchronous `reset_n` assertion mid-load returns everything to reset values immediately. A partial word is discarded and never written.

## Configuration

- `LOADER_CHECKSUM_EN` defined:
  - After the final word (or after a zero length header), the FSM enters CHECK and accepts one more byte.
  - That byte must equal the XOR of every data byte, with length bytes excluded.
  - Match goes to DONE; mismatch goes to ERROR.
  - A running 8-bit XOR is kept and cleared on `start`.
- `LOADER_CHECKSUM_EN` undefined: no CHECK state and no checksum logic. The last write goes directly to DONE.

## Structure

- `loader_pkg` contains:
  - `loader_state_t` enum (IDLE, LEN0, LEN1, DATA, WRITE, CHECK, DONE, ERROR);
  - `LEN_WIDTH`=16;
  - `BYTES_PER_WORD`=4.
- One sub-module, `word_assembler`: it shifts in bytes under an accept strobe, counts to 4 and flags `word_ready`; it is cleared on `start`/reset.

## Test plan

- Two-word load: `start`, then bytes 02 00 | 93 00 50 00 | b3 02 11 00.
  - Required response: writes 32'h00500093 at `BASE_ADDR`, then 32'h001102b3 at `BASE_ADDR`+4.
  - `done`=1, `core_reset`=0, `words_loaded`=2.
- Stalled source: same stream with `byte_valid` toggled every other cycle.
  - Required response: identical writes, and no byte accepted while `byte_ready`=0.
- Oversize header: length 65 with `DEPTH_WORDS`=64.
  - Required response: ERROR after LEN1, `mem_we` never asserted, `core_reset` stays 1.
- Mid-load reset: drop `reset_n` after 2 bytes of word 1.
  - Required response: all outputs at reset values immediately, and no write of the partial word.
- Zero length: header 00 00.
  - Required response: DONE with no writes (checksum off); with `LOADER_CHECKSUM_EN`, a checksum byte 00 is required to reach DONE.
- Checksum enabled: two-word stream followed by a wrong checksum byte.
  - Required response: both words written, then `error`=1 and `done`=0.
  - Re-`start` with the correct checksum byte yields `done`=1.
